// File: rtl/alu_mdu_ctrl.sv
// alu_mdu_ctrl: ALU control decode plus a one-bit-per-cycle multiply/divide unit.
// Optional macro MDU_DIV_EN adds the restoring divider (DIV/DIVU/REM/REMU).
module alu_mdu_ctrl #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        ALUOp_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic              start_i,
  input  logic [XLEN-1:0]   src1_i,
  input  logic [XLEN-1:0]   src2_i,
  output logic [CTRL_W-1:0] ALU_Ctrl_o,
  output logic              stall_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [XLEN-1:0]   mdu_result_o
);

  localparam int unsigned PW    = 2 * XLEN;
  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1000;
  localparam logic [3:0] OP_MDU = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // ---------------------------------------------------------------- ALU decode
  logic [3:0] base_code;
  logic [3:0] alu_code;
  logic       is_mdu;

  assign is_mdu = (ALUOp_i == 2'b10) && (funct7_i == 7'b0000001);

  always_comb begin
    base_code = OP_ADD;
    case (funct3_i)
      3'b001:  base_code = OP_SLL;
      3'b010:  base_code = OP_SLT;
      3'b100:  base_code = OP_XOR;
      3'b101:  base_code = OP_SRL;
      3'b110:  base_code = OP_OR;
      3'b111:  base_code = OP_AND;
      default: base_code = OP_ADD;
    endcase
  end

  always_comb begin
    alu_code = OP_ADD;
    case (ALUOp_i)
      2'b00: alu_code = OP_ADD;
      2'b01: alu_code = OP_SUB;
      2'b10: begin
        if (funct7_i == 7'b0000000) begin
          alu_code = base_code;
        end else if (funct7_i == 7'b0100000) begin
          if (funct3_i == 3'b000)      alu_code = OP_SUB;
          else if (funct3_i == 3'b101) alu_code = OP_SRA;
        end else if (funct7_i == 7'b0000001) begin
          alu_code = OP_MDU;
        end
      end
      default: begin
        // Immediate forms: only the shift-right pair looks at funct7.
        alu_code = base_code;
        if ((funct3_i == 3'b101) && funct7_i[5]) alu_code = OP_SRA;
      end
    endcase
  end

  assign ALU_Ctrl_o = CTRL_W'(alu_code);

  // ------------------------------------------------------------- MDU datapath
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic              neg_res_q, neg_res_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [XLEN-1:0]   res_d;
  logic              busy_d, done_d;

  logic              sgn_a, sgn_b, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;

  // Operand A is signed for MULH/MULHSU/DIV/REM, operand B for MULH/DIV/REM.
  assign sgn_a = funct3_i[2] ? ~funct3_i[0] : (funct3_i[1] ^ funct3_i[0]);
  assign sgn_b = funct3_i[2] ? ~funct3_i[0] : (funct3_i[1:0] == 2'b01);
  assign a_neg = sgn_a & src1_i[XLEN-1];
  assign b_neg = sgn_b & src2_i[XLEN-1];
  assign a_mag = a_neg ? (XLEN'(0) - src1_i) : src1_i;
  assign b_mag = b_neg ? (XLEN'(0) - src2_i) : src2_i;

  // Shift-add step: low half holds the multiplier, high half accumulates.
  logic [XLEN:0]     mul_sum;
  logic [PW-1:0]     prod_step, prod_fin;
  logic [XLEN-1:0]   mul_res;

  assign mul_sum   = {1'b0, prod_q[PW-1:XLEN]} + ({1'b0, opb_q} & {(XLEN+1){prod_q[0]}});
  assign prod_step = {mul_sum, prod_q[XLEN-1:1]};
  assign prod_fin  = neg_res_q ? (PW'(0) - prod_step) : prod_step;
  assign mul_res   = (op_q == 2'b00) ? prod_fin[XLEN-1:0] : prod_fin[PW-1:XLEN];

`ifdef MDU_DIV_EN
  logic              neg_rem_q, neg_rem_d;
  logic              dz_q, dz_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN:0]     div_shift, div_trial;
  logic              div_ge;
  logic [XLEN-1:0]   quo_step, rem_step, quo_fin, rem_fin, div_res;

  // Restoring step: dividend bits stream out of quo_q into the remainder.
  assign div_shift = {rem_q, quo_q[XLEN-1]};
  assign div_trial = div_shift - {1'b0, opb_q};
  assign div_ge    = ~div_trial[XLEN];
  assign rem_step  = div_ge ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
  assign quo_step  = {quo_q[XLEN-2:0], div_ge};
  assign quo_fin   = dz_q ? {XLEN{1'b1}} : (neg_res_q ? (XLEN'(0) - quo_step) : quo_step);
  assign rem_fin   = neg_rem_q ? (XLEN'(0) - rem_step) : rem_step;
  assign div_res   = op_q[1] ? rem_fin : quo_fin;
`endif

  // ------------------------------------------------------------------ MDU FSM
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    opb_d     = opb_q;
    prod_d    = prod_q;
    res_d     = mdu_result_o;
`ifdef MDU_DIV_EN
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i && is_mdu) begin
          op_d      = funct3_i[1:0];
          neg_res_d = a_neg ^ b_neg;
          opb_d     = b_mag;
          cnt_d     = '0;
          if (!funct3_i[2]) begin
            state_d = MUL;
            prod_d  = {{XLEN{1'b0}}, a_mag};
          end else begin
`ifdef MDU_DIV_EN
            state_d   = DIV;
            neg_rem_d = a_neg;
            dz_d      = (src2_i == '0);
            quo_d     = a_mag;
            rem_d     = '0;
`else
            state_d   = DONE;
            res_d     = '0;
`endif
          end
        end
      end
      MUL: begin
        prod_d = prod_step;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d = DONE;
          res_d   = mul_res;
        end
      end
`ifdef MDU_DIV_EN
      DIV: begin
        quo_d = quo_step;
        rem_d = rem_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d = DONE;
          res_d   = div_res;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == MUL) || (state_d == DIV);
    done_d = (state_d == DONE);
  end

  assign stall_o = ((state_q == IDLE) && start_i && is_mdu) ||
                   (state_q == MUL) || (state_q == DIV);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      neg_res_q    <= 1'b0;
      opb_q        <= '0;
      prod_q       <= '0;
      mdu_result_o <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
`ifdef MDU_DIV_EN
      neg_rem_q    <= 1'b0;
      dz_q         <= 1'b0;
      quo_q        <= '0;
      rem_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      neg_res_q    <= neg_res_d;
      opb_q        <= opb_d;
      prod_q       <= prod_d;
      mdu_result_o <= res_d;
      busy_o       <= busy_d;
      done_o       <= done_d;
`ifdef MDU_DIV_EN
      neg_rem_q    <= neg_rem_d;
      dz_q         <= dz_d;
      quo_q        <= quo_d;
      rem_q        <= rem_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// tb_alu_mdu_ctrl: directed checks of ALU decode and MDU timing/results for alu_mdu_ctrl.
module tb_alu_mdu_ctrl;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 4;

  logic              clk_i;
  logic              rst_i;
  logic [1:0]        ALUOp_i;
  logic [2:0]        funct3_i;
  logic [6:0]        funct7_i;
  logic              start_i;
  logic [XLEN-1:0]   src1_i;
  logic [XLEN-1:0]   src2_i;
  logic [CTRL_W-1:0] ALU_Ctrl_o;
  logic              stall_o;
  logic              busy_o;
  logic              done_o;
  logic [XLEN-1:0]   mdu_result_o;

  int compared   = 0;
  int mismatched = 0;

  alu_mdu_ctrl #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ALUOp_i      (ALUOp_i),
    .funct3_i     (funct3_i),
    .funct7_i     (funct7_i),
    .start_i      (start_i),
    .src1_i       (src1_i),
    .src2_i       (src2_i),
    .ALU_Ctrl_o   (ALU_Ctrl_o),
    .stall_o      (stall_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .mdu_result_o (mdu_result_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic dec(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                     input logic [3:0] exp, input string tag);
    ALUOp_i  = op;
    funct7_i = f7;
    funct3_i = f3;
    #1;
    chk(tag, 64'(ALU_Ctrl_o), 64'(exp));
  endtask

  // Issue one MDU op, optionally pulse start again at cycle inj, then check timing and result.
  task automatic run_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat, input int inj,
                         input string tag);
    int n;
    int stall_n;
    int busy_n;
    ALUOp_i  = 2'b10;
    funct7_i = 7'b0000001;
    funct3_i = f3;
    src1_i   = a;
    src2_i   = b;
    start_i  = 1'b1;
    #1;
    chk({tag, "/stall_accept"}, 64'(stall_o), 64'(1));
    @(posedge clk_i); #1;
    start_i = 1'b0;
    n       = 1;
    stall_n = 1;
    busy_n  = 0;
    while (done_o !== 1'b1 && n < 200) begin
      if (stall_o) stall_n++;
      if (busy_o)  busy_n++;
      start_i = (n == inj);
      if (n == inj) begin
        src1_i = a ^ 32'h0000_5A5A;
        src2_i = b + 32'd3;
      end
      @(posedge clk_i); #1;
      n++;
    end
    start_i = 1'b0;
    chk({tag, "/latency"},     64'(n),            64'(exp_lat));
    chk({tag, "/stall_cycles"}, 64'(stall_n),     64'(exp_lat));
    chk({tag, "/busy_cycles"}, 64'(busy_n),       64'(exp_lat - 1));
    chk({tag, "/stall_done"},  64'(stall_o),      64'(0));
    chk({tag, "/result"},      64'(mdu_result_o), 64'(exp_res));
    // A start presented in DONE must not be accepted.
    funct3_i = 3'b000;
    src1_i   = 32'd2;
    src2_i   = 32'd2;
    start_i  = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk({tag, "/done_pulse"},  64'(done_o),       64'(0));
    chk({tag, "/start_in_done_busy"}, 64'(busy_o), 64'(0));
    chk({tag, "/held"},        64'(mdu_result_o), 64'(exp_res));
  endtask

  initial begin
    rst_i    = 1'b1;
    start_i  = 1'b0;
    ALUOp_i  = 2'b00;
    funct3_i = 3'b000;
    funct7_i = 7'b0000000;
    src1_i   = '0;
    src2_i   = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst/busy",   64'(busy_o),       64'(0));
    chk("rst/done",   64'(done_o),       64'(0));
    chk("rst/result", 64'(mdu_result_o), 64'(0));
    chk("rst/stall",  64'(stall_o),      64'(0));
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    dec(2'b10, 7'b0100000, 3'b000, 4'b0110, "dec/r_sub");
    dec(2'b11, 7'b0000000, 3'b111, 4'b0000, "dec/i_and");
    dec(2'b10, 7'b0000000, 3'b011, 4'b0010, "dec/r_undef011");
    dec(2'b00, 7'b0100000, 3'b101, 4'b0010, "dec/ldsd");
    dec(2'b01, 7'b0000001, 3'b111, 4'b0110, "dec/beq");
    dec(2'b10, 7'b0000000, 3'b000, 4'b0010, "dec/r_add");
    dec(2'b10, 7'b0000000, 3'b001, 4'b0100, "dec/r_sll");
    dec(2'b10, 7'b0000000, 3'b010, 4'b0111, "dec/r_slt");
    dec(2'b10, 7'b0000000, 3'b100, 4'b0011, "dec/r_xor");
    dec(2'b10, 7'b0000000, 3'b101, 4'b0101, "dec/r_srl");
    dec(2'b10, 7'b0000000, 3'b110, 4'b0001, "dec/r_or");
    dec(2'b10, 7'b0100000, 3'b101, 4'b1000, "dec/r_sra");
    dec(2'b10, 7'b0100000, 3'b111, 4'b0010, "dec/r_undef_alt");
    dec(2'b10, 7'b1111111, 3'b001, 4'b0010, "dec/r_undef_f7");
    dec(2'b10, 7'b0000001, 3'b110, 4'b1111, "dec/r_mdu");
    dec(2'b11, 7'b0100000, 3'b000, 4'b0010, "dec/i_addi");
    dec(2'b11, 7'b0100000, 3'b101, 4'b1000, "dec/i_srai");
    dec(2'b11, 7'b0000000, 3'b101, 4'b0101, "dec/i_srli");
    dec(2'b11, 7'b1111111, 3'b010, 4'b0111, "dec/i_slti");
    dec(2'b11, 7'b0000000, 3'b011, 4'b0010, "dec/i_undef011");

    // Non-MDU start leaves the FSM alone.
    ALUOp_i  = 2'b10;
    funct7_i = 7'b0000000;
    funct3_i = 3'b000;
    start_i  = 1'b1;
    #1;
    chk("nonmdu/stall", 64'(stall_o), 64'(0));
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk("nonmdu/busy", 64'(busy_o), 64'(0));
    chk("nonmdu/done", 64'(done_o), 64'(0));

    run_mdu(3'b000, 32'd7,          32'd6,          32'd42,         33, 0,  "mul_7x6");
    run_mdu(3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33, 0,  "mulhu_max");
    run_mdu(3'b000, 32'hFFFF_FFFF,  32'd3,          32'hFFFF_FFFD,  33, 0,  "mul_lo_wrap");
    run_mdu(3'b001, 32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  33, 0,  "mulh_neg");
    run_mdu(3'b001, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000,  33, 0,  "mulh_min_m1");
    run_mdu(3'b010, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33, 0,  "mulhsu_min");
    run_mdu(3'b000, 32'd5,          32'd5,          32'd25,         33, 10, "mul_busy_ignore");

    // Reset in the middle of a multiply.
    ALUOp_i  = 2'b10;
    funct7_i = 7'b0000001;
    funct3_i = 3'b000;
    src1_i   = 32'd7;
    src2_i   = 32'd7;
    start_i  = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (9) begin
      @(posedge clk_i); #1;
    end
    chk("midrst/busy_before", 64'(busy_o), 64'(1));
    rst_i = 1'b1;
    #1;
    chk("midrst/busy",   64'(busy_o),       64'(0));
    chk("midrst/done",   64'(done_o),       64'(0));
    chk("midrst/result", 64'(mdu_result_o), 64'(0));
    chk("midrst/stall",  64'(stall_o),      64'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    chk("midrst/no_done", 64'(done_o), 64'(0));
    run_mdu(3'b000, 32'd3, 32'd3, 32'd9, 33, 0, "mul_after_rst");

`ifdef MDU_DIV_EN
    run_mdu(3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33, 0,  "div_m7_2");
    run_mdu(3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33, 0,  "rem_m7_2");
    run_mdu(3'b101, 32'd100,        32'd0,          32'hFFFF_FFFF,  33, 0,  "divu_by0");
    run_mdu(3'b111, 32'd100,        32'd0,          32'd100,        33, 0,  "remu_by0");
    run_mdu(3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33, 0,  "div_ovf");
    run_mdu(3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000,  33, 0,  "rem_ovf");
    run_mdu(3'b100, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  33, 0,  "div_neg_by0");
    run_mdu(3'b110, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  33, 0,  "rem_neg_by0");
    run_mdu(3'b101, 32'd100,        32'd7,          32'd14,         33, 12, "divu_busy_ignore");
`else
    run_mdu(3'b100, 32'd100,        32'd7,          32'd0,          1,  0,  "div_disabled");
    run_mdu(3'b000, 32'd4,          32'd4,          32'd16,         33, 0,  "mul_between");
    run_mdu(3'b111, 32'd100,        32'd0,          32'd0,          1,  0,  "remu_disabled");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
